// File: rtl/alu_pkg.sv
// Shared types for the multicycle ALU: op encoding, FSM states, flag bit positions.
package alu_pkg;

   typedef enum logic [2:0] {
      OP_ADD   = 3'b000,
      OP_SUB   = 3'b001,
      OP_AND   = 3'b010,
      OP_OR    = 3'b011,
      OP_EOR   = 3'b100,
      OP_MUL   = 3'b101,
      OP_UMULH = 3'b110,
      OP_RSVD  = 3'b111
   } alu_op_e;

   typedef enum logic {
      IDLE = 1'b0,
      MUL  = 1'b1
   } state_e;

   localparam int unsigned FLAG_N = 3;
   localparam int unsigned FLAG_Z = 2;
   localparam int unsigned FLAG_C = 1;
   localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add unsigned multiplier, one partial product per step.
// MUL_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are all zero.
module mul_iter #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic               step,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               finish,
   output logic [2*WIDTH-1:0] product
);

   logic [2*WIDTH-1:0] mcand, mcand_nxt, acc, acc_nxt;
   logic [WIDTH-1:0]   mplier, mplier_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;

   always_comb begin
      acc_nxt    = mplier[0] ? acc + mcand : acc;
      mcand_nxt  = mcand << 1;
      mplier_nxt = mplier >> 1;
      cnt_nxt    = cnt + CNT_W'(1);
      product    = acc_nxt;
`ifdef MUL_EARLY_TERM_EN
      // the count term is redundant here but keeps a hard WIDTH-step ceiling
      finish     = step && ((mplier_nxt == '0) || (cnt_nxt == CNT_W'(WIDTH)));
`else
      finish     = step && (cnt_nxt == CNT_W'(WIDTH));
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         cnt    <= '0;
      end else if (load) begin
         mcand  <= {{WIDTH{1'b0}}, a};
         mplier <= b;
         acc    <= '0;
         cnt    <= '0;
      end else if (step) begin
         mcand  <= mcand_nxt;
         mplier <= mplier_nxt;
         acc    <= acc_nxt;
         cnt    <= cnt_nxt;
      end
   end

endmodule

// File: rtl/multicycle_alu.sv
// Registered ALU with start/busy/done handshake and an iterative multiplier.
// Optional macro MUL_EARLY_TERM_EN shortens multiplies (see mul_iter).
module multicycle_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [3:0]       flags
);

   localparam int CNT_W = $clog2(WIDTH) + 1;

   state_e             state, state_nxt;
   alu_op_e            op_e;
   logic               hi_q, hi_nxt;
   logic               load, step, finish, done_nxt;
   logic [2*WIDTH-1:0] product;
   logic [WIDTH-1:0]   alu_res, mul_res, res_nxt;
   logic [3:0]         alu_flg, flg_nxt;
   logic [WIDTH:0]     sum;

   assign op_e = alu_op_e'(op);
   assign busy = (state == MUL);

   mul_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_mul (
      .clk    (clk),
      .reset  (reset),
      .load   (load),
      .step   (step),
      .a      (src_a),
      .b      (src_b),
      .finish (finish),
      .product(product)
   );

   always_comb begin
      sum     = '0;
      alu_res = '0;
      alu_flg = '0;
      case (op_e)
         OP_ADD: begin
            sum             = {1'b0, src_a} + {1'b0, src_b};
            alu_res         = sum[WIDTH-1:0];
            alu_flg[FLAG_C] = sum[WIDTH];
            alu_flg[FLAG_V] = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (alu_res[WIDTH-1] != src_a[WIDTH-1]);
         end
         OP_SUB: begin
            sum             = {1'b0, src_a} + {1'b0, ~src_b} + {{WIDTH{1'b0}}, 1'b1};
            alu_res         = sum[WIDTH-1:0];
            alu_flg[FLAG_C] = sum[WIDTH];
            alu_flg[FLAG_V] = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (alu_res[WIDTH-1] != src_a[WIDTH-1]);
         end
         OP_AND:  alu_res = src_a & src_b;
         OP_OR:   alu_res = src_a | src_b;
         OP_EOR:  alu_res = src_a ^ src_b;
         default: alu_res = '0;
      endcase
      alu_flg[FLAG_N] = alu_res[WIDTH-1];
      alu_flg[FLAG_Z] = (alu_res == '0);
   end

   assign mul_res = hi_q ? product[2*WIDTH-1:WIDTH] : product[WIDTH-1:0];

   always_comb begin
      state_nxt = state;
      hi_nxt    = hi_q;
      load      = 1'b0;
      step      = 1'b0;
      done_nxt  = 1'b0;
      res_nxt   = result;
      flg_nxt   = flags;
      case (state)
         IDLE: begin
            if (start) begin
               if (op_e == OP_MUL || op_e == OP_UMULH) begin
                  load      = 1'b1;
                  hi_nxt    = (op_e == OP_UMULH);
                  state_nxt = MUL;
               end else begin
                  done_nxt = 1'b1;
                  res_nxt  = alu_res;
                  flg_nxt  = alu_flg;
               end
            end
         end
         MUL: begin
            step = 1'b1;
            if (finish) begin
               done_nxt        = 1'b1;
               res_nxt         = mul_res;
               flg_nxt         = '0;
               flg_nxt[FLAG_N] = mul_res[WIDTH-1];
               flg_nxt[FLAG_Z] = (mul_res == '0);
               state_nxt       = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         hi_q   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
         flags  <= '0;
      end else begin
         state  <= state_nxt;
         hi_q   <= hi_nxt;
         done   <= done_nxt;
         result <= res_nxt;
         flags  <= flg_nxt;
      end
   end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed self-checking bench for multicycle_alu (honours MUL_EARLY_TERM_EN if defined).
module tb_multicycle_alu;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic [31:0] src_a, src_b;
   logic        busy, done;
   logic [31:0] result;
   logic [3:0]  flags;

   int tests = 0;
   int fails = 0;

`ifdef MUL_EARLY_TERM_EN
   localparam int MUL_LAT = 2;
`else
   localparam int MUL_LAT = 32;
`endif

   multicycle_alu #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .src_a (src_a),
      .src_b (src_b),
      .busy  (busy),
      .done  (done),
      .result(result),
      .flags (flags)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
      start = 1'b1;
      op    = o;
      src_a = a;
      src_b = b;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin : stim
      int n;
      int dones;
      reset = 1'b0;
      start = 1'b0;
      op    = 3'b000;
      src_a = '0;
      src_b = '0;
      #12;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_result", 64'(result), 64'd0);
      chk("rst_flags", 64'(flags), 64'd0);
      reset = 1'b1;
      tick();

      // ADD overflow
      drive(3'b000, 32'h7FFF_FFFF, 32'h0000_0001);
      tick();
      start = 1'b0;
      chk("add_done", 64'(done), 64'd1);
      chk("add_result", 64'(result), 64'h8000_0000);
      chk("add_flags", 64'(flags), 64'b1001);
      tick();
      chk("add_done_pulse", 64'(done), 64'd0);
      chk("add_result_hold", 64'(result), 64'h8000_0000);

      // SUB equal and borrow
      drive(3'b001, 32'd5, 32'd5);
      tick();
      chk("sub_eq_result", 64'(result), 64'd0);
      chk("sub_eq_flags", 64'(flags), 64'b0110);
      drive(3'b001, 32'd3, 32'd5);
      tick();
      start = 1'b0;
      chk("sub_lt_result", 64'(result), 64'hFFFF_FFFE);
      chk("sub_lt_flags", 64'(flags), 64'b1000);
      tick();

      // Back-to-back EOR then OR
      drive(3'b100, 32'hF0F0_F0F0, 32'hFFFF_FFFF);
      tick();
      chk("eor_done", 64'(done), 64'd1);
      chk("eor_result", 64'(result), 64'h0F0F_0F0F);
      chk("eor_flags", 64'(flags), 64'b0000);
      drive(3'b011, 32'd0, 32'd0);
      tick();
      start = 1'b0;
      chk("or_done", 64'(done), 64'd1);
      chk("or_result", 64'(result), 64'd0);
      chk("or_flags", 64'(flags), 64'b0100);
      tick();

      // Reserved op
      drive(3'b111, 32'h1234_5678, 32'h1);
      tick();
      start = 1'b0;
      chk("rsvd_done", 64'(done), 64'd1);
      chk("rsvd_flags", 64'(flags), 64'b0100);
      tick();

      // MUL low word, with an ADD start pulsed while busy
      drive(3'b101, 32'hFFFF_FFFF, 32'h0000_0002);
      tick();
      chk("mul_busy", 64'(busy), 64'd1);
      chk("mul_done_e0", 64'(done), 64'd0);
      drive(3'b000, 32'd1, 32'd1);
      tick();
      start = 1'b0;
      op    = 3'b110;
      src_a = '0;
      src_b = '0;
      n = 1;
      chk("mul_ignore_add", 64'(result), 64'h0000_0000);
      while (!done && n < 40) begin
         tick();
         n++;
      end
      chk("mul_latency", 64'(n), 64'(MUL_LAT));
      chk("mul_result", 64'(result), 64'hFFFF_FFFE);
      chk("mul_flags", 64'(flags), 64'b1000);
      chk("mul_busy_end", 64'(busy), 64'd0);
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done) dones++;
      end
      chk("mul_no_extra_done", 64'(dones), 64'd0);
      chk("mul_result_hold", 64'(result), 64'hFFFF_FFFE);

      // UMULH
      drive(3'b110, 32'hFFFF_FFFF, 32'h0000_0002);
      tick();
      start = 1'b0;
      n = 0;
      while (!done && n < 40) begin
         tick();
         n++;
      end
      chk("umulh_latency", 64'(n), 64'(MUL_LAT));
      chk("umulh_result", 64'(result), 64'h0000_0001);
      chk("umulh_flags", 64'(flags), 64'b0000);
      tick();

      // Reset mid-multiply (high multiplier bit keeps it running the full length)
      drive(3'b101, 32'd3, 32'h8000_0000);
      tick();
      start = 1'b0;
      repeat (9) tick();
      chk("rst_mid_busy_before", 64'(busy), 64'd1);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_mid_busy", 64'(busy), 64'd0);
      chk("rst_mid_done", 64'(done), 64'd0);
      chk("rst_mid_result", 64'(result), 64'd0);
      chk("rst_mid_flags", 64'(flags), 64'd0);
      @(negedge clk);
      reset = 1'b1;
      dones = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (done) dones++;
      end
      chk("rst_mid_no_done", 64'(dones), 64'd0);
      chk("rst_mid_result_after", 64'(result), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/multicycle_alu.md
Name: multicycle_alu

Overview:
- Parametrised successor to the single-cycle datapath ALU.
- Adds EOR and an iterative shift-add unsigned multiplier (low and high word) behind a start/busy/done handshake.
- Result and flags are registered, so this block replaces the ALU and ALUOut register pair in the multicycle datapath.
- The control FSM issues `start` and waits on `done` before advancing.

Parameters:
WIDTH, 32, operand/result width in bits (>=8)
CNT_W, $clog2(WIDTH)+1, width of the iteration counter (derived; not overridden)

Ports:
clk  input  1  clock, rising-edge
reset  input  1  asynchronous, active-low reset; 0 = reset asserted
start  input  1  one-cycle request; operands and op sampled when start=1 and busy=0
op  input  3  operation, encoded by alu_op_e
src_a  input  WIDTH  operand A
src_b  input  WIDTH  operand B
busy  output  1  multiply in progress
done  output  1  one-cycle pulse; result/flags valid from this cycle on
result  output  WIDTH  registered result, held until next completion
flags  output  4  registered {N,Z,C,V}, held until next completion

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, busy=0, done=0, result=0, flags=0. Takes effect mid-multiply: operation aborted, nothing completes.
- Op encoding: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 EOR, 101 MUL (low WIDTH bits of unsigned product), 110 UMULH (high WIDTH bits), 111 reserved.
- States: IDLE, MUL.
- Single-cycle ops (000-100, 111):
  - start sampled at edge E0 -> result, flags, done=1 visible after E0. State stays IDLE.
  - Back-to-back starts every cycle are legal; done=1 each cycle.
- Flags for single-cycle ops:
  - N=result[WIDTH-1]; Z=(result==0).
  - ADD: C=carry-out; V=(A,B same sign) and (result sign differs).
  - SUB: computed A+~B+1; C=carry-out (1 = no borrow); V=(A,B signs differ) and (result sign differs from A).
  - AND/OR/EOR: C=0, V=0.
  - Reserved op: result=0, flags=4'b0100, done still pulses.
- Multiply (101/110):
  - E0: load mcand = 2W-bit zero-extended A; mplier = B; acc=0; cnt=0; state MUL; busy=1.
  - Each following edge: if mplier[0], acc += mcand; then mcand <<= 1, mplier >>= 1, cnt++.
  - At the edge where cnt reaches WIDTH: result = acc low or high half per the latched op; flags N,Z from result, C=0, V=0; done=1; busy=0; state IDLE.
  - Done is therefore visible after E_WIDTH, WIDTH edges after E0.
  - The op is latched at E0; changes on op/src_* during MUL are ignored.
- start while busy=1: ignored; no queueing, no error.
- start on the done edge of a multiply: busy=0 in that cycle, so it is accepted.
- done is high for exactly one cycle per completion.
- result/flags are unchanged between completions, including while busy.

Optional Feature:
MUL_EARLY_TERM_EN
- Defined: multiply completes at the first step edge after which the shifted mplier==0. This includes mplier=0 at E0, which completes at E1. Result and flags are identical to the full iteration.
- Undefined: always exactly WIDTH step edges.

Decomposition:
- Package alu_pkg: typedef enum logic[2:0] alu_op_e; typedef enum state_e {IDLE, MUL}; flag bit index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- One sub-module, mul_iter: the shift-add engine (mcand/mplier/acc/cnt registers, step enable, finish output). The top holds the FSM, the single-cycle ALU and the output registers.

Test Plan:
- Reset: reset=0 mid-MUL at cycle 10 -> busy=0, done=0, result=0, flags=0 immediately; after release, no done pulse.
- ADD 0x7FFFFFFF+0x00000001 -> result 0x80000000, flags 4'b1001, done one edge after start.
- SUB 5-5 -> result 0, flags 4'b0110. SUB 3-5 -> result 0xFFFFFFFE, flags 4'b1000.
- MUL 0xFFFFFFFF*0x00000002 -> result 0xFFFFFFFE, flags 4'b1000. UMULH same operands -> result 0x00000001, flags 4'b0000. Done 32 edges after start without the macro, 2 edges with MUL_EARLY_TERM_EN.
- start ADD pulsed while busy (MUL in progress) -> ignored: no extra done, result changes only at MUL completion.
- Back-to-back: EOR 0xF0F0F0F0^0xFFFFFFFF then OR 0,0 on consecutive cycles -> done on both cycles; results 0x0F0F0F0F then 0x00000000 with flags 4'b0100.
